// File: rtl/nios2_avalon_st_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nios2_avalon_st_adapter_pkg
// Description : Shared types and constants for the Avalon-ST timing adapter
//               transmit path.
//               - ST_DATA_WIDTH            default payload width
//               - st_data_t                payload type at the default width
//               - ST_TX_MAX_READY_LATENCY  largest supported sink ready latency
//               - buf_op_e                 per-edge buffer operation encoding
// Revision    : 1.0 - initial release
// ============================================================================
package nios2_avalon_st_adapter_pkg;

  localparam int ST_DATA_WIDTH           = 42;
  localparam int ST_TX_MAX_READY_LATENCY = 4;

  typedef logic [ST_DATA_WIDTH-1:0] st_data_t;

  // Encoding is {push, pop} so the buffer can cast its two strobes directly.
  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_POP  = 2'b01,
    BUF_PUSH = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  // True when a ready latency can be served by the transmit stage.
  function automatic bit st_tx_rl_legal(input int rl);
    return (rl >= 1) && (rl <= ST_TX_MAX_READY_LATENCY);
  endfunction

endpackage : nios2_avalon_st_adapter_pkg
`default_nettype wire

// File: rtl/nios2_avalon_st_adapter_timing_adapter_0_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : nios2_avalon_st_adapter_timing_adapter_0_tx_if
// Description : One Avalon-ST link (valid / ready / data).
//               master : drives valid and data, receives ready
//               slave  : receives valid and data, drives ready
//               Parameter DATA_WIDTH sets the payload width.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios2_avalon_st_adapter_timing_adapter_0_tx_if
  import nios2_avalon_st_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = ST_DATA_WIDTH
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface : nios2_avalon_st_adapter_timing_adapter_0_tx_if
`default_nettype wire

// File: rtl/nios2_avalon_st_adapter_tx_buf.sv
`default_nettype none
// ============================================================================
// Module      : nios2_avalon_st_adapter_tx_buf
// Description : Pointer/flag FIFO for the timing adapter transmit path.
//               Registered full/empty flags; the memory is read at the read
//               pointer and captured by the caller's output register.
//               Optional macro NIOS2_ST_TX_FILL_LEVEL_EN adds fill_level_o.
// Ports       : clk          clock, posedge
//               reset_n      asynchronous active-low reset
//               push_i       write wr_data_i (ignored while full)
//               pop_i        advance read pointer (ignored while empty)
//               wr_data_i    write payload
//               rd_data_o    entry at the read pointer
//               full_o       registered full flag
//               empty_o      registered empty flag
//               fill_level_o occupancy 0..BUF_DEPTH (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_avalon_st_adapter_tx_buf
  import nios2_avalon_st_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = ST_DATA_WIDTH,
  parameter int BUF_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   fill_level_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_rd_next;
  buf_op_e               w_op;

  // Local guards keep the flags consistent even if a caller strobes blindly.
  assign w_push    = push_i & ~full_q;
  assign w_pop     = pop_i & ~empty_q;
  assign w_op      = buf_op_e'({w_push, w_pop});

  // BUF_DEPTH is a power of two, so plain increment wraps the pointers.
  assign w_wr_next = wr_ptr_q + ADDR_WIDTH'(1);
  assign w_rd_next = rd_ptr_q + ADDR_WIDTH'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    case (w_op)
      BUF_PUSH: begin
        wr_ptr_d = w_wr_next;
        empty_d  = 1'b0;
        full_d   = (w_wr_next == rd_ptr_q);
      end
      BUF_POP: begin
        rd_ptr_d = w_rd_next;
        full_d   = 1'b0;
        empty_d  = (w_rd_next == wr_ptr_q);
      end
      BUF_BOTH: begin
        // Occupancy unchanged, so both flags hold.
        wr_ptr_d = w_wr_next;
        rd_ptr_d = w_rd_next;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset: resetting the pointers already discards contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
  // Pointer difference is ambiguous at 0 vs BUF_DEPTH; the full flag resolves it.
  assign fill_level_o = full_q ? (ADDR_WIDTH+1)'(BUF_DEPTH)
                               : {1'b0, ADDR_WIDTH'(wr_ptr_q - rd_ptr_q)};
`endif

endmodule : nios2_avalon_st_adapter_tx_buf
`default_nettype wire

// File: rtl/nios2_avalon_st_adapter_timing_adapter_0_tx.sv
`default_nettype none
// ============================================================================
// Module      : nios2_avalon_st_adapter_timing_adapter_0_tx
// Description : Transmit side of the Avalon-ST timing adapter. Accepts a
//               ready-latency-0 stream, buffers it, and drives a sink that
//               grants a beat slot READY_LATENCY cycles after out_ready.
//               Optional macro NIOS2_ST_TX_FILL_LEVEL_EN adds fill_level_o.
// Ports       : clk          clock, posedge
//               reset_n      asynchronous active-low reset
//               in_st        slave link  (upstream valid/data in, ready out)
//               out_st       master link (valid/data out, sink ready in)
//               fill_level_o buffer occupancy 0..BUF_DEPTH (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module nios2_avalon_st_adapter_timing_adapter_0_tx
  import nios2_avalon_st_adapter_pkg::*;
#(
  parameter int DATA_WIDTH    = ST_DATA_WIDTH,
  parameter int BUF_DEPTH     = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int READY_LATENCY = 1
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  nios2_avalon_st_adapter_timing_adapter_0_tx_if.slave   in_st,
  nios2_avalon_st_adapter_timing_adapter_0_tx_if.master  out_st
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]                            fill_level_o
`endif
);

  localparam bit RL_LEGAL = st_tx_rl_legal(READY_LATENCY);

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_slot_next;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;

  // Upstream side: ready depends only on the registered full flag.
  assign in_st.ready = ~w_full;
  assign w_push      = in_st.valid & ~w_full;

  // --------------------------------------------------------------------------
  // Ready history. slot_next is out_ready as seen READY_LATENCY-1 cycles
  // before the upcoming edge; a beat launched on that edge lands exactly in
  // the cycle the sink granted.
  // --------------------------------------------------------------------------
  generate
    if (READY_LATENCY <= 1) begin : g_rl_direct
      assign w_slot_next = out_st.ready;
    end else begin : g_rl_hist
      logic [READY_LATENCY-2:0] hist_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hist_q <= '0;
        end else begin
          hist_q[0] <= out_st.ready;
          for (int k = 1; k < READY_LATENCY - 1; k++) begin
            hist_q[k] <= hist_q[k-1];
          end
        end
      end

      assign w_slot_next = hist_q[READY_LATENCY-2];
    end
  endgenerate

  // Illegal latencies never grant a slot rather than misplacing beats.
  assign w_pop = RL_LEGAL & w_slot_next & ~w_empty;

  nios2_avalon_st_adapter_tx_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_tx_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (w_push),
    .pop_i        (w_pop),
    .wr_data_i    (in_st.data),
    .rd_data_o    (w_rd_data),
    .full_o       (w_full),
    .empty_o      (w_empty)
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    ,
    .fill_level_o (fill_level_o)
`endif
  );

  // --------------------------------------------------------------------------
  // Output register stage. A beat is launched only into a granted slot; the
  // sink must take it, so there is no hold/retry path. Data holds otherwise.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d = w_pop;
    out_data_d  = out_data_q;
    if (w_pop) begin
      out_data_d = w_rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_st.valid = out_valid_q;
  assign out_st.data  = out_data_q;

endmodule : nios2_avalon_st_adapter_timing_adapter_0_tx
`default_nettype wire

// File: tb/tb_nios2_avalon_st_adapter_timing_adapter_0_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios2_avalon_st_adapter_timing_adapter_0_tx
// Description : Directed bench for the timing adapter transmit path.
//               Instance a: READY_LATENCY=1 (reset, latency, fill/drain,
//                           push+pop, mid-stream reset)
//               Instance b: READY_LATENCY=2 (random traffic vs queue model)
//               Instance c: READY_LATENCY=3 (slot discipline)
//               fill_level checks exist only with NIOS2_ST_TX_FILL_LEVEL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios2_avalon_st_adapter_timing_adapter_0_tx;
  import nios2_avalon_st_adapter_pkg::*;

  localparam int DW = 42;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) a_in ();
  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) a_out ();
  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) b_in ();
  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) b_out ();
  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) c_in ();
  nios2_avalon_st_adapter_timing_adapter_0_tx_if #(.DATA_WIDTH(DW)) c_out ();

`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
  logic [3:0] a_fill;
  logic [3:0] b_fill;
  logic [3:0] c_fill;
`endif

  nios2_avalon_st_adapter_timing_adapter_0_tx #(
    .DATA_WIDTH(DW), .BUF_DEPTH(8), .ADDR_WIDTH(3), .READY_LATENCY(1)
  ) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .in_st   (a_in),
    .out_st  (a_out)
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    ,
    .fill_level_o (a_fill)
`endif
  );

  nios2_avalon_st_adapter_timing_adapter_0_tx #(
    .DATA_WIDTH(DW), .BUF_DEPTH(8), .ADDR_WIDTH(3), .READY_LATENCY(2)
  ) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .in_st   (b_in),
    .out_st  (b_out)
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    ,
    .fill_level_o (b_fill)
`endif
  );

  nios2_avalon_st_adapter_timing_adapter_0_tx #(
    .DATA_WIDTH(DW), .BUF_DEPTH(8), .ADDR_WIDTH(3), .READY_LATENCY(3)
  ) u_dut_c (
    .clk     (clk),
    .reset_n (reset_n),
    .in_st   (c_in),
    .out_st  (c_out)
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    ,
    .fill_level_o (c_fill)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pat [10];
    int          nd;
    logic [DW-1:0] q [$];
    logic [DW-1:0] d;
    logic [63:0] r;
    bit          prev_rdy;
    bit          cur_rdy;
    bit          acc;
    bit          exp_v;

    pat = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    c_in.valid = 1'b0; c_in.data = '0; c_out.ready = 1'b0;

    // ---------------- reset / idle ----------------
    #2;
    chk("rst_a_in_ready", a_in.ready, 1);
    chk("rst_a_valid",    a_out.valid, 0);
    chk("rst_a_data",     a_out.data, 0);
    chk("rst_b_in_ready", b_in.ready, 1);
    chk("rst_b_valid",    b_out.valid, 0);
    chk("rst_c_valid",    c_out.valid, 0);
    chk("rst_c_data",     c_out.data, 0);
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    chk("rst_a_fill", a_fill, 0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_a_valid", a_out.valid, 0);

    // ---------------- latency, RL=1 ----------------
    a_out.ready = 1'b1;
    a_in.valid  = 1'b1;
    a_in.data   = DW'(1);
    tick();                                   // edge e: push
    a_in.valid  = 1'b0;
    chk("lat_e",        a_out.valid, 0);
    tick();                                   // edge e+1: launch
    chk("lat_e1_valid", a_out.valid, 1);
    chk("lat_e1_data",  a_out.data, 1);
    tick();
    chk("lat_e2_valid", a_out.valid, 0);
    chk("lat_e2_hold",  a_out.data, 1);

    // ---------------- fill and drain ----------------
    a_out.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fill_in_ready", a_in.ready, 1);
      a_in.valid = 1'b1;
      a_in.data  = DW'(i);
      tick();
    end
    a_in.data = DW'(12'hBAD);                 // offered while full: dropped
    chk("full_in_ready", a_in.ready, 0);
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    chk("full_fill", a_fill, 8);
`endif
    tick();
    a_in.valid = 1'b0;
    chk("full_hold_in_ready", a_in.ready, 0);
    chk("full_no_valid",      a_out.valid, 0);
    a_out.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("drain_valid", a_out.valid, 1);
      chk("drain_data",  a_out.data, k);
      if (k == 0) chk("drain_first_in_ready", a_in.ready, 1);
    end
    tick();
    chk("drain_empty_valid", a_out.valid, 0);
    chk("drain_empty_hold",  a_out.data, 7);

    // ---------------- simultaneous push/pop at level 4 ----------------
    a_out.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in.valid = 1'b1;
      a_in.data  = DW'(32'h100 + i);
      tick();
    end
    a_out.ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      a_in.data = DW'(32'h104 + j);
      tick();
      chk("pp_valid",    a_out.valid, 1);
      chk("pp_data",     a_out.data, 32'h100 + j);
      chk("pp_in_ready", a_in.ready, 1);
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
      chk("pp_fill", a_fill, 4);
`endif
    end
    a_in.valid = 1'b0;
    for (int j = 10; j < 14; j++) begin
      tick();
      chk("pp_tail_data", a_out.data, 32'h100 + j);
    end
    tick();
    chk("pp_end_valid", a_out.valid, 0);
    a_out.ready = 1'b0;

    // ---------------- slot discipline, RL=3 ----------------
    for (int i = 0; i < 5; i++) begin
      c_in.valid = 1'b1;
      c_in.data  = DW'(32'h400 + i);
      tick();
    end
    c_in.valid = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      c_out.ready = pat[i][0];
      tick();
      exp_v = (i >= 2) ? pat[i-2][0] : 1'b0;
      chk("slot_valid", c_out.valid, exp_v);
      if (exp_v) begin
        chk("slot_data", c_out.data, 32'h400 + nd);
        nd++;
      end
    end
    c_out.ready = 1'b0;

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 6; i++) begin
      a_in.valid = 1'b1;
      a_in.data  = DW'(32'h200 + i);
      tick();
    end
    a_in.valid  = 1'b0;
    a_out.ready = 1'b1;
    tick();
    chk("mrst_pre_valid", a_out.valid, 1);
    chk("mrst_pre_data",  a_out.data, 32'h200);
    a_out.ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mrst_valid",    a_out.valid, 0);
    chk("mrst_data",     a_out.data, 0);
    chk("mrst_in_ready", a_in.ready, 1);
    #3;
    reset_n = 1'b1;
    tick();
    chk("mrst_post_in_ready", a_in.ready, 1);
    chk("mrst_post_valid",    a_out.valid, 0);
`ifdef NIOS2_ST_TX_FILL_LEVEL_EN
    chk("mrst_post_fill", a_fill, 0);
`endif
    a_out.ready = 1'b1;
    a_in.valid  = 1'b1;
    a_in.data   = DW'(32'h300);
    tick();
    a_in.valid  = 1'b0;
    chk("mrst_next_e",     a_out.valid, 0);
    tick();
    chk("mrst_next_valid", a_out.valid, 1);
    chk("mrst_next_data",  a_out.data, 32'h300);
    a_out.ready = 1'b0;

    // ---------------- random, RL=2 ----------------
    prev_rdy = 1'b0;
    for (int cyc = 0; cyc < 340; cyc++) begin
      r = {$urandom(), $urandom()};
      d = r[DW-1:0];
      if (cyc < 320) begin
        b_in.valid  = ($urandom_range(0, 3) != 0);
        b_out.ready = ($urandom_range(0, 2) != 0);
      end else begin
        b_in.valid  = 1'b0;
        b_out.ready = 1'b1;
      end
      b_in.data = d;
      cur_rdy = b_out.ready;
      acc     = b_in.valid && (q.size() < 8);
      exp_v   = prev_rdy && (q.size() > 0);
      chk("rnd_in_ready", b_in.ready, (q.size() < 8));
      tick();
      chk("rnd_valid", b_out.valid, exp_v);
      chk("rnd_slot",  b_out.valid & ~prev_rdy, 0);
      if (exp_v) begin
        chk("rnd_data", b_out.data, q[0]);
        void'(q.pop_front());
      end
      if (acc) q.push_back(d);
      prev_rdy = cur_rdy;
    end
    b_out.ready = 1'b0;
    chk("rnd_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nios2_avalon_st_adapter_timing_adapter_0_tx
`default_nettype wire
